// File: rtl/answer_write_arbiter_pkg.sv
// Shared parameters and types for the answer write arbiter: shared-memory answer
// layout defaults, the arbiter state type and an index-width helper.
package answer_write_arbiter_pkg;

    localparam logic [31:0] DEF_OUT_BASEADDR = 32'hA000_0800;
    localparam int          DEF_SLOT_BYTES   = 64;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // Width of an index into n items; never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/answer_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_i,
// wrapping modulo N; last_i itself is considered last.
module rr_pick
    import answer_write_arbiter_pkg::*;
#(
    parameter int N  = 15,
    parameter int IW = 4
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    int cand_s;

    // Scan offsets 1..N from the last grant and keep the first hit.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand_s  = 0;
        for (int k = 1; k <= N; k++) begin
            cand_s = (int'(last_i) + k) % N;
            if (!found_o && req_i[cand_s]) begin
                found_o = 1'b1;
                idx_o   = IW'(cand_s);
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule

// File: rtl/answer_write_arbiter.sv
// Packet-locked round-robin arbiter that streams per-task answer words into the
// TX FIFO, placing each requester's packet in its own shared-memory slot.
module answer_write_arbiter
    import answer_write_arbiter_pkg::*;
#(
    parameter int                    NUM_REQ      = 15,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] OUT_BASEADDR = ADDR_WIDTH'(DEF_OUT_BASEADDR),
    parameter int                    SLOT_BYTES   = DEF_SLOT_BYTES
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_clear,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic [ADDR_WIDTH-1:0]         tx_addr,
    output logic                          tx_wr_en,
    input  logic                          tx_full,
    output logic [NUM_REQ-1:0]            done_mask,
    output logic                          overflow_err,
    output logic                          busy
);

    localparam int IW    = idx_width(NUM_REQ);
    localparam int WORDS = SLOT_BYTES / 4;
    localparam int WW    = idx_width(WORDS);

    localparam logic [WW-1:0] WCNT_MAX  = WW'(WORDS - 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

    state_t               state_q, state_d;
    logic [IW-1:0]        g_q, g_d;
    logic [IW-1:0]        last_q, last_d;
    logic [WW-1:0]        wcnt_q, wcnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0] words_s [NUM_REQ];
    logic [NUM_REQ-1:0]    eligible_s;
    logic [IW-1:0]         pick_idx_s;
    logic                  pick_found_s;
    logic                  in_xfer_s;
    logic                  beat_s;
    logic                  at_end_s;
    logic                  final_beat_s;

    // Slice the flat request data bus into per-requester words.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words_s[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign eligible_s = req_valid & ~done_q;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req_i   (eligible_s),
        .last_i  (last_q),
        .idx_o   (pick_idx_s),
        .found_o (pick_found_s)
    );

    assign in_xfer_s    = (state_q == ST_XFER) && !i_rst;
    assign beat_s       = in_xfer_s && req_valid[g_q] && !tx_full;
    assign at_end_s     = (wcnt_q == WCNT_MAX);
    assign final_beat_s = beat_s && (req_last[g_q] || at_end_s);

    // Only the granted requester sees ready, and only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        if (in_xfer_s && !tx_full) begin
            req_ready[g_q] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    assign tx_wr_en     = beat_s;
    assign tx_data      = words_s[g_q];
    assign tx_addr      = OUT_BASEADDR
                        + ADDR_WIDTH'(g_q) * ADDR_WIDTH'(SLOT_BYTES)
                        + ADDR_WIDTH'({wcnt_q, 2'b00});
    assign busy         = in_xfer_s;
    assign done_mask    = done_q;
    assign overflow_err = ovf_q;

    // Next-state: grant in IDLE, count beats in XFER, clear overrides sticky flags.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        wcnt_d  = wcnt_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    g_d     = pick_idx_s;
                    wcnt_d  = '0;
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (final_beat_s) begin
                    done_d[g_q] = 1'b1;
                    last_d      = g_q;
                    wcnt_d      = '0;
                    state_d     = ST_IDLE;
                end else if (beat_s) begin
                    wcnt_d = wcnt_q + WW'(1);
                end else begin
                    wcnt_d = wcnt_q;
                end
                // A slot filled without a last marker truncates the packet.
                if (beat_s && at_end_s && !req_last[g_q]) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = ovf_d;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (i_clear) begin
            done_d = '0;
            ovf_d  = 1'b0;
            last_d = LAST_INIT;
        end else begin
            done_d = done_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            wcnt_q  <= '0;
            last_q  <= LAST_INIT;
            done_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            wcnt_q  <= wcnt_d;
            last_q  <= last_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_answer_write_arbiter.sv
// Directed bench for answer_write_arbiter with a per-cycle behavioural model.
module tb_answer_write_arbiter;

    localparam int N  = 15;
    localparam int DW = 32;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_clear;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic [DW-1:0]     tx_data;
    logic [31:0]       tx_addr;
    logic              tx_wr_en;
    logic              tx_full;
    logic [N-1:0]      done_mask;
    logic              overflow_err;
    logic              busy;

    answer_write_arbiter dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (i_clear),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_addr      (tx_addr),
        .tx_wr_en     (tx_wr_en),
        .tx_full      (tx_full),
        .done_mask    (done_mask),
        .overflow_err (overflow_err),
        .busy         (busy)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    int  pend [N];
    int  seq  [N];
    bit  use_last [N];
    logic [31:0] wr_log [$];

    bit          m_init = 1'b0;
    bit          m_busy;
    int          m_owner;
    int          m_cnt;
    int          m_last;
    logic [N-1:0] m_done;
    logic        m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: evaluate expected outputs from current state/inputs, then advance.
    always @(negedge i_clk) begin
        logic [N-1:0] e_ready;
        logic         e_wr;
        bit           found;
        int           cand;
        if (tx_wr_en === 1'b1) wr_log.push_back(tx_addr);
        if (i_rst === 1'b1) begin
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_wr_en", 32'(tx_wr_en), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            m_init = 1'b1; m_busy = 1'b0; m_owner = 0; m_cnt = 0;
            m_last = N - 1; m_done = '0; m_ovf = 1'b0;
        end else if (m_init) begin
            e_wr    = m_busy && req_valid[m_owner] && !tx_full;
            e_ready = '0;
            if (m_busy && !tx_full) e_ready[m_owner] = 1'b1;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("tx_wr_en", 32'(tx_wr_en), 32'(e_wr));
            chk("done_mask", 32'(done_mask), 32'(m_done));
            chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
            if (m_busy) begin
                chk("tx_addr", tx_addr, 32'hA000_0800 + 32'(m_owner * 64) + 32'(m_cnt * 4));
                chk("tx_data", tx_data, req_data[m_owner*DW +: DW]);
            end
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    cand = (m_last + k) % N;
                    if (!found && req_valid[cand] && !m_done[cand]) begin
                        found = 1'b1; m_owner = cand;
                    end
                end
                if (found) begin m_busy = 1'b1; m_cnt = 0; end
            end else if (e_wr) begin
                if (req_last[m_owner] || m_cnt == 15) begin
                    if (!req_last[m_owner]) m_ovf = 1'b1;
                    m_done[m_owner] = 1'b1;
                    m_last = m_owner;
                    m_busy = 1'b0;
                end else begin
                    m_cnt++;
                end
            end
            if (i_clear) begin m_done = '0; m_ovf = 1'b0; m_last = N - 1; end
        end
    end

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (pend[i] > 0);
            req_last[i]  = use_last[i] && (pend[i] == 1);
            req_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
        end
    endtask

    // One clock: note which words were accepted, then present the next words.
    task automatic step();
        logic [N-1:0] acc;
        @(negedge i_clk);
        acc = req_ready;
        @(posedge i_clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] === 1'b1) begin seq[i]++; pend[i]--; end
        end
        drive_inputs();
    endtask

    task automatic wait_log(input int n, input int bound, input string name);
        int c = 0;
        while (wr_log.size() < n && c < bound) begin step(); c++; end
        chk(name, 32'(wr_log.size()), 32'(n));
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1; step(); i_clear = 1'b0;
    endtask

    task automatic load(input int r, input int words, input bit with_last);
        pend[r] = words; seq[r] = 0; use_last[r] = with_last; drive_inputs();
    endtask

    initial begin
        i_rst = 1'b1; i_clear = 1'b0; tx_full = 1'b0;
        for (int i = 0; i < N; i++) begin pend[i] = 0; seq[i] = 0; use_last[i] = 1'b1; end
        drive_inputs();
        step(); step();
        i_rst = 1'b0;
        step();
        chk("reset_done", 32'(done_mask), 32'd0);
        chk("reset_ovf", 32'(overflow_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Three-word packet from requester 2.
        wr_log.delete(); load(2, 3, 1'b1);
        wait_log(3, 40, "s1_len");
        chk("s1_a0", wr_log[0], 32'hA000_0880);
        chk("s1_a1", wr_log[1], 32'hA000_0884);
        chk("s1_a2", wr_log[2], 32'hA000_0888);
        chk("s1_done", 32'(done_mask), 32'h0004);
        chk("s1_busy", 32'(busy), 32'd0);

        // Requesters 0 and 14 together: 0 wins after a clear.
        pulse_clear(); wr_log.delete();
        load(0, 1, 1'b1); load(14, 1, 1'b1);
        wait_log(2, 40, "s2_len");
        chk("s2_a0", wr_log[0], 32'hA000_0800);
        chk("s2_a1", wr_log[1], 32'hA000_0B80);
        chk("s2_done", 32'(done_mask), 32'h4001);

        // FIFO full for five cycles mid-packet.
        pulse_clear(); wr_log.delete(); load(3, 4, 1'b1);
        wait_log(2, 40, "s3_pre");
        tx_full = 1'b1;
        repeat (5) step();
        chk("s3_stall", 32'(wr_log.size()), 32'd2);
        tx_full = 1'b0;
        wait_log(4, 40, "s3_len");
        chk("s3_a2", wr_log[2], 32'hA000_08C8);
        chk("s3_a3", wr_log[3], 32'hA000_08CC);

        // Seventeen words, no last: slot overflows after sixteen.
        pulse_clear(); wr_log.delete(); load(1, 17, 1'b0);
        wait_log(16, 80, "s4_len");
        chk("s4_first", wr_log[0], 32'hA000_0840);
        chk("s4_last", wr_log[15], 32'hA000_087C);
        chk("s4_ovf", 32'(overflow_err), 32'd1);
        chk("s4_done1", 32'(done_mask[1]), 32'd1);
        repeat (5) step();
        chk("s4_held", 32'(wr_log.size()), 32'd16);
        use_last[1] = 1'b1; drive_inputs();
        pulse_clear();
        chk("s4_ovf_clr", 32'(overflow_err), 32'd0);
        wait_log(17, 40, "s4_len2");
        chk("s4_17th", wr_log[16], 32'hA000_0840);

        // Clear lands on requester 5's final beat.
        pulse_clear(); wr_log.delete(); load(5, 2, 1'b1);
        wait_log(1, 40, "s5_pre");
        i_clear = 1'b1; step(); i_clear = 1'b0;
        chk("s5_len", 32'(wr_log.size()), 32'd2);
        chk("s5_a1", wr_log[1], 32'hA000_0944);
        chk("s5_done", 32'(done_mask), 32'd0);
        chk("s5_busy", 32'(busy), 32'd0);

        // Reset after two of four words abandons the packet.
        pulse_clear(); wr_log.delete(); load(0, 4, 1'b1);
        wait_log(2, 40, "s6_pre");
        i_rst = 1'b1; step(); i_rst = 1'b0;
        chk("s6_busy", 32'(busy), 32'd0);
        chk("s6_wr_en", 32'(tx_wr_en), 32'd0);
        wr_log.delete(); load(0, 4, 1'b1);
        wait_log(4, 40, "s6_len");
        chk("s6_a0", wr_log[0], 32'hA000_0800);
        chk("s6_a3", wr_log[3], 32'hA000_080C);
        chk("s6_done", 32'(done_mask), 32'h0001);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/answer_write_arbiter.md
ANSWER_WRITE_ARBITER -- requirements
Module: answer_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 15, SHALL be the number of answer requesters; requester i serves task i+1.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL be the answer word and TX FIFO data width.
REQ-003 Parameter ADDR_WIDTH, default 32, SHALL be the TX FIFO address width.
REQ-004 Parameter OUT_BASEADDR, default 32'hA000_0800, SHALL be the shared-memory answer base address.
REQ-005 Parameter SLOT_BYTES, default 64, a power of two and at least 4, SHALL be the per-requester answer slot size.
REQ-006 Port i_clk, input, 1: the single clock; one clock domain; synchronous, active-high reset.
REQ-007 Port i_rst, input, 1: synchronous active-high reset.
REQ-008 Port i_clear, input, 1: single-cycle pulse that starts a new test round.
REQ-009 Port req_valid, input, NUM_REQ: requester i has an answer word.
REQ-010 Port req_data, input, NUM_REQ*DATA_WIDTH: word i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 Port req_last, input, NUM_REQ: the current word is the final word of the packet.
REQ-012 Port req_ready, output, NUM_REQ: the word from requester i is accepted this cycle.
REQ-013 Port tx_data, output, DATA_WIDTH: TX FIFO write data.
REQ-014 Port tx_addr, output, ADDR_WIDTH: TX FIFO write address.
REQ-015 Port tx_wr_en, output, 1: TX FIFO write strobe.
REQ-016 Port tx_full, input, 1: TX FIFO full.
REQ-017 Port done_mask, output, NUM_REQ: sticky flag per requester, set when its packet has been written.
REQ-018 Port overflow_err, output, 1: sticky flag, set when any packet exceeds its slot.
REQ-019 Port busy, output, 1: high in state XFER.

Function
REQ-020 The FSM SHALL have two states. IDLE: no grant. XFER: packet-locked grant to requester g.
REQ-021 In IDLE, eligible requesters SHALL be those with req_valid set and done_mask clear.
REQ-022 When any requester is eligible, the FSM SHALL select the first eligible index at or after last_grant+1, wrapping modulo NUM_REQ. It SHALL register g, clear wcnt, and enter XFER next cycle; no word is accepted in that cycle.
REQ-023 In XFER, req_ready[g] SHALL equal ~tx_full. Every other req_ready bit SHALL be 0, and every req_ready bit SHALL be 0 in IDLE.
REQ-024 tx_wr_en SHALL equal (state==XFER) & req_valid[g] & ~tx_full, combinationally, with zero-cycle latency.
REQ-025 tx_data SHALL be word g.
REQ-026 tx_addr SHALL be OUT_BASEADDR + g*SLOT_BYTES + wcnt*4, computed modulo 2^ADDR_WIDTH.
REQ-027 Each accepted word SHALL increment wcnt, of width log2(SLOT_BYTES/4).
REQ-028 A beat is final when req_last[g] is set or wcnt==SLOT_BYTES/4-1.
REQ-029 On a final beat: done_mask[g] SHALL be set, last_grant SHALL be loaded with g, and the FSM SHALL return to IDLE.
REQ-030 If wcnt==SLOT_BYTES/4-1 on a beat and req_last[g] is clear, overflow_err SHALL be set.
REQ-031 While tx_full is high, no beat is accepted, and wcnt, g and the state SHALL hold.
REQ-032 i_clear SHALL zero done_mask and overflow_err and load last_grant with NUM_REQ-1. It SHALL NOT abort a packet in XFER.
REQ-033 When i_clear coincides with a final beat, clear SHALL win: that done bit ends at 0.
REQ-034 A deasserted req_valid[g] in XFER SHALL stall without releasing the grant.

Reset
REQ-035 i_rst SHALL force: state IDLE, g=0, wcnt=0, last_grant=NUM_REQ-1, done_mask=0, overflow_err=0.
REQ-036 Under i_rst, req_ready, tx_wr_en and busy SHALL be 0.
REQ-037 i_rst mid-packet SHALL abandon the packet. The next cycle SHALL be IDLE with no write.

Structure
REQ-038 OUT_BASEADDR and SLOT_BYTES defaults, plus the state enum type, SHALL reside in the shared tasks parameters package.
REQ-039 The round-robin pick SHALL be a sub-module rr_pick (request vector, last index -> index, found), purely combinational.
REQ-040 No other sub-modules SHALL exist.

Verification
REQ-041 Scenario: after reset, req_valid[2]=1 with 3 words (last on the 3rd) and tx_full=0. Required: writes at 0xA000_0880, 0x884, 0x888; done_mask=0x0004; busy low afterwards.
REQ-042 Scenario: req_valid[0] and req_valid[14] both set, 1-word packets. Required: requester 0 is served first (addr 0xA000_0800), then 14 (addr 0xA000_0B80); done_mask=0x4001.
REQ-043 Scenario: tx_full held high for 5 cycles mid-packet. Required: no tx_wr_en and wcnt holds; the addresses remain contiguous after release.
REQ-044 Scenario: requester 1 sends 17 words with no last. Required: 16 writes (0x840..0x87C); overflow_err=1; done_mask[1]=1; the 17th word is not accepted until after i_clear.
REQ-045 Scenario: i_clear coincides with requester 5's final beat. Required: the write occurs and done_mask[5]=0.
REQ-046 Scenario: i_rst asserted in XFER after 2 of 4 words. Required: next cycle IDLE and tx_wr_en=0. After release, requester 0 is re-granted and restarts at 0xA000_0800.
